// File: rtl/frame_mode_sequencer.sv
// frame_mode_sequencer
//   Frame-synchronous mode controller for the capture-side filter datapath.
//   Debounces the user mode request and applies a new mode only between frames.
//   On a switch it flushes the convolution line buffers, and after a switch into
//   convolution mode it masks valid until the buffers hold PRIME_LINES lines.
//   Optional build macro MODE_SEQ_STATS_EN: when defined, oSWITCH_CNT counts
//   applied switches and saturates at 8'hFF. When undefined, oSWITCH_CNT is 8'h00.
module frame_mode_sequencer #(
  parameter int DEBOUNCE_CYC = 1024,
  parameter int FLUSH_CYC    = 4,
  parameter int PRIME_LINES  = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [1:0] iMODE_REQ,
  input  logic       iFVAL,
  input  logic       iLVAL,
  input  logic       iDVAL_RAW,
  input  logic       iDVAL_CONV,
  output logic       oFILTER_TYPE,
  output logic       oSEL_CONV,
  output logic       oFLUSH,
  output logic       oVALID,
  output logic       oBUSY,
  output logic [7:0] oSWITCH_CNT
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int FLUSH_W = $clog2(FLUSH_CYC + 1);
  localparam int PRIME_W = $clog2(PRIME_LINES + 1);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_WAIT_EOF = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_APPLY    = 3'd3,
    ST_WAIT_SOF = 3'd4,
    ST_PRIME    = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [1:0]         mode_sync1_r;
  logic [1:0]         mode_sync2_r;
  logic [1:0]         mode_cand_r;
  logic [DEB_W-1:0]   deb_cnt_r;
  logic [1:0]         pending_r;
  logic [1:0]         active_r;
  logic               fval_r;
  logic               fval_d_r;
  logic               lval_r;
  logic               lval_d_r;
  logic [FLUSH_W-1:0] flush_cnt_r;
  logic [PRIME_W-1:0] prime_cnt_r;
  logic               fval_rise_s;
  logic               fval_fall_s;
  logic               lval_fall_s;
  logic               flush_done_s;
  logic               prime_done_s;

  // Two-flop synchroniser for the asynchronous mode switches
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mode_sync1_r <= 2'b00;
      mode_sync2_r <= 2'b00;
    end else begin
      mode_sync1_r <= iMODE_REQ;
      mode_sync2_r <= mode_sync1_r;
    end
  end

  // Stability counter: pending takes the synchronised value once it has held long enough
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mode_cand_r <= 2'b00;
      deb_cnt_r   <= '0;
      pending_r   <= 2'b00;
    end else if (mode_sync2_r != mode_cand_r) begin
      mode_cand_r <= mode_sync2_r;
      deb_cnt_r   <= '0;
    end else if (deb_cnt_r != DEB_W'(DEBOUNCE_CYC - 1)) begin
      deb_cnt_r   <= deb_cnt_r + DEB_W'(1);
    end else begin
      pending_r   <= mode_cand_r;
    end
  end

  // Registered copies of frame/line valid for edge detection
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      fval_r   <= 1'b0;
      fval_d_r <= 1'b0;
      lval_r   <= 1'b0;
      lval_d_r <= 1'b0;
    end else begin
      fval_r   <= iFVAL;
      fval_d_r <= fval_r;
      lval_r   <= iLVAL;
      lval_d_r <= lval_r;
    end
  end

  assign fval_rise_s  = fval_r & ~fval_d_r;
  assign fval_fall_s  = ~fval_r & fval_d_r;
  assign lval_fall_s  = ~lval_r & lval_d_r;
  assign flush_done_s = (flush_cnt_r == FLUSH_W'(FLUSH_CYC - 1));
  assign prime_done_s = lval_fall_s && (prime_cnt_r == PRIME_W'(PRIME_LINES - 1));

  // Flush duration counter, cleared whenever the FSM is outside FLUSH
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      flush_cnt_r <= '0;
    end else if (state_r == ST_FLUSH) begin
      flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
    end else begin
      flush_cnt_r <= '0;
    end
  end

  // Primed-line counter: counts line ends in PRIME, cleared on leaving PRIME
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      prime_cnt_r <= '0;
    end else if (state_r != ST_PRIME) begin
      prime_cnt_r <= '0;
    end else if (lval_fall_s) begin
      prime_cnt_r <= prime_cnt_r + PRIME_W'(1);
    end else begin
      prime_cnt_r <= prime_cnt_r;
    end
  end

  // Active mode only changes in APPLY, which is always between frames
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      active_r <= 2'b00;
    end else if (state_r == ST_APPLY) begin
      active_r <= pending_r;
    end else begin
      active_r <= active_r;
    end
  end

  // FSM state register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_r <= ST_WAIT_SOF;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (pending_r != active_r) state_s = ST_WAIT_EOF;
        else                       state_s = ST_RUN;
      end
      ST_WAIT_EOF: begin
        // Covers both the end of the current frame and an idle bus on entry
        if (!fval_r) state_s = ST_FLUSH;
        else         state_s = ST_WAIT_EOF;
      end
      ST_FLUSH: begin
        if (flush_done_s) state_s = ST_APPLY;
        else              state_s = ST_FLUSH;
      end
      ST_APPLY: begin
        state_s = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (fval_rise_s) state_s = active_r[1] ? ST_PRIME : ST_RUN;
        else             state_s = ST_WAIT_SOF;
      end
      ST_PRIME: begin
        if (fval_fall_s)       state_s = ST_WAIT_SOF;
        else if (prime_done_s) state_s = ST_RUN;
        else                   state_s = ST_PRIME;
      end
      default: begin
        state_s = ST_WAIT_SOF;
      end
    endcase
  end

  // FSM outputs: valid gate (zero latency), flush strobe, busy flag
  always_comb begin
    oVALID = 1'b0;
    oFLUSH = 1'b0;
    oBUSY  = 1'b1;
    case (state_r)
      ST_RUN: begin
        oVALID = active_r[1] ? iDVAL_CONV : iDVAL_RAW;
        oBUSY  = 1'b0;
      end
      ST_WAIT_EOF: begin
        oVALID = active_r[1] ? iDVAL_CONV : iDVAL_RAW;
      end
      ST_FLUSH: begin
        oFLUSH = 1'b1;
      end
      default: begin
        oVALID = 1'b0;
      end
    endcase
  end

  assign oFILTER_TYPE = active_r[0];
  assign oSEL_CONV    = active_r[1];

`ifdef MODE_SEQ_STATS_EN
  logic [7:0] switch_cnt_r;

  // Saturating count of applied mode switches
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      switch_cnt_r <= 8'h00;
    end else if ((state_r == ST_APPLY) && (switch_cnt_r != 8'hFF)) begin
      switch_cnt_r <= switch_cnt_r + 8'd1;
    end else begin
      switch_cnt_r <= switch_cnt_r;
    end
  end

  assign oSWITCH_CNT = switch_cnt_r;
`else
  assign oSWITCH_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_frame_mode_sequencer.sv
// Testbench for frame_mode_sequencer. Uses a short debounce window so the
// saturation scenario (300 switches) stays short.
module tb_frame_mode_sequencer;

  localparam int DEB = 32;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic [1:0] iMODE_REQ;
  logic       iFVAL, iLVAL, iDVAL_RAW, iDVAL_CONV;
  logic       oFILTER_TYPE, oSEL_CONV, oFLUSH, oVALID, oBUSY;
  logic [7:0] oSWITCH_CNT;

  int n_checks = 0;
  int n_fail   = 0;
  int n_switch = 0;

  frame_mode_sequencer #(.DEBOUNCE_CYC(DEB), .FLUSH_CYC(4), .PRIME_LINES(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMODE_REQ(iMODE_REQ),
    .iFVAL(iFVAL), .iLVAL(iLVAL), .iDVAL_RAW(iDVAL_RAW), .iDVAL_CONV(iDVAL_CONV),
    .oFILTER_TYPE(oFILTER_TYPE), .oSEL_CONV(oSEL_CONV), .oFLUSH(oFLUSH),
    .oVALID(oVALID), .oBUSY(oBUSY), .oSWITCH_CNT(oSWITCH_CNT)
  );

  always #5 iCLK = ~iCLK;

  // Expected switch counter from the number of applied switches
  function automatic logic [7:0] exp_cnt();
`ifdef MODE_SEQ_STATS_EN
    return (n_switch > 255) ? 8'hFF : 8'(n_switch);
`else
    return 8'h00;
`endif
  endfunction

  // One clock: inputs change just after the rising edge, outputs are sampled on the falling edge
  task automatic drive(input logic fv, input logic lv, input logic dr, input logic dc);
    @(posedge iCLK);
    #1;
    iFVAL = fv; iLVAL = lv; iDVAL_RAW = dr; iDVAL_CONV = dc;
    @(negedge iCLK);
  endtask

  task automatic test_reset();
    @(negedge iCLK);
    n_checks++;
    if ({oFILTER_TYPE, oSEL_CONV, oFLUSH, oVALID, oBUSY} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_outs: got ft/sel/flush/valid/busy=%b expected 00001",
               {oFILTER_TYPE, oSEL_CONV, oFLUSH, oVALID, oBUSY});
    end
    n_checks++;
    if (oSWITCH_CNT !== 8'h00) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", oSWITCH_CNT);
    end
  endtask

  // First frame after reset releases mode 00 straight to RUN; valid follows raw
  task automatic test_run_raw();
    logic dr, dc;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      dr = 1'($urandom); dc = 1'($urandom);
      drive(1'b1, 1'($urandom), dr, dc);
      n_checks++;
      if (oVALID !== dr || oBUSY !== 1'b0 || oSEL_CONV !== 1'b0 || oFILTER_TYPE !== 1'b0) begin
        n_fail++;
        $display("FAIL run_raw: got valid=%b busy=%b sel=%b ft=%b expected valid=%b busy=0 sel=0 ft=0",
                 oVALID, oBUSY, oSEL_CONV, oFILTER_TYPE, dr);
      end
    end
  endtask

  // Request conv mode mid-frame; nothing changes until the frame ends, then flush and apply
  task automatic test_switch_conv();
    logic dr, dc;
    int flush_seen;
    iMODE_REQ = 2'b10;
    for (int i = 0; i < DEB + 40; i++) begin
      dr = 1'($urandom); dc = 1'($urandom);
      drive(1'b1, 1'b0, dr, dc);
      n_checks++;
      if (oVALID !== dr || oSEL_CONV !== 1'b0 || oFLUSH !== 1'b0) begin
        n_fail++;
        $display("FAIL switch_midframe: got valid=%b sel=%b flush=%b expected valid=%b sel=0 flush=0",
                 oVALID, oSEL_CONV, oFLUSH, dr);
      end
    end
    flush_seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      if (oFLUSH === 1'b1) begin
        flush_seen++;
        n_checks++;
        if (oVALID !== 1'b0 || oSEL_CONV !== 1'b0) begin
          n_fail++;
          $display("FAIL switch_flush: got valid=%b sel=%b during flush expected 0 0", oVALID, oSEL_CONV);
        end
      end
    end
    n_switch++;
    n_checks++;
    if (flush_seen != 4) begin
      n_fail++; $display("FAIL switch_flush_len: got %0d cycles expected 4", flush_seen);
    end
    n_checks++;
    if (oSEL_CONV !== 1'b1 || oFILTER_TYPE !== 1'b0 || oBUSY !== 1'b1 || oSWITCH_CNT !== exp_cnt()) begin
      n_fail++;
      $display("FAIL switch_applied: got sel=%b ft=%b busy=%b cnt=%0d expected 1 0 1 %0d",
               oSEL_CONV, oFILTER_TYPE, oBUSY, oSWITCH_CNT, exp_cnt());
    end
  endtask

  // Next conv frame: first two lines masked, later lines follow iDVAL_CONV
  task automatic test_prime();
    logic dr, dc, expv;
    int len;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'($urandom), 1'($urandom));
      n_checks++;
      if (oVALID !== 1'b0) begin
        n_fail++; $display("FAIL prime_sof: got valid=%b expected 0", oVALID);
      end
    end
    for (int ln = 0; ln < 5; ln++) begin
      len = $urandom_range(8, 20);
      for (int p = 0; p < len; p++) begin
        dr = 1'($urandom); dc = 1'($urandom);
        drive(1'b1, 1'b1, dr, dc);
        expv = (ln >= 2) ? dc : 1'b0;
        n_checks++;
        if (oVALID !== expv) begin
          n_fail++;
          $display("FAIL prime_line%0d: got valid=%b expected %b", ln, oVALID, expv);
        end
      end
      repeat (8) drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Short glitch on the request is filtered: no switch, no busy, no flush
  task automatic test_glitch();
    int glen;
    glen = $urandom_range(4, DEB / 2);
    iMODE_REQ = 2'b11;
    for (int i = 0; i < glen + DEB * 2; i++) begin
      if (i == glen) iMODE_REQ = 2'b10;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (oBUSY !== 1'b0 || oFLUSH !== 1'b0) begin
        n_fail++; $display("FAIL glitch: got busy=%b flush=%b expected 0 0", oBUSY, oFLUSH);
      end
    end
    n_checks++;
    if (oSEL_CONV !== 1'b1 || oFILTER_TYPE !== 1'b0 || oSWITCH_CNT !== exp_cnt()) begin
      n_fail++;
      $display("FAIL glitch_mode: got sel=%b ft=%b cnt=%0d expected 1 0 %0d",
               oSEL_CONV, oFILTER_TYPE, oSWITCH_CNT, exp_cnt());
    end
  endtask

  // Pending changes again while waiting for end of frame: latest value wins, one switch
  task automatic test_pending_update();
    logic dc;
    int flush_seen;
    iMODE_REQ = 2'b00;
    for (int i = 0; i < DEB + 10; i++) begin
      dc = 1'($urandom);
      drive(1'b1, 1'b0, 1'($urandom), dc);
      n_checks++;
      if (oVALID !== dc) begin
        n_fail++; $display("FAIL pend_oldmode: got valid=%b expected %b", oVALID, dc);
      end
    end
    n_checks++;
    if (oBUSY !== 1'b1) begin
      n_fail++; $display("FAIL pend_waiteof: got busy=%b expected 1", oBUSY);
    end
    iMODE_REQ = 2'b11;
    for (int i = 0; i < DEB + 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (oFLUSH !== 1'b0 || oSEL_CONV !== 1'b1 || oFILTER_TYPE !== 1'b0) begin
        n_fail++;
        $display("FAIL pend_hold: got flush=%b sel=%b ft=%b expected 0 1 0", oFLUSH, oSEL_CONV, oFILTER_TYPE);
      end
    end
    flush_seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (oFLUSH === 1'b1) flush_seen++;
    end
    n_switch++;
    n_checks++;
    if (flush_seen != 4 || oSEL_CONV !== 1'b1 || oFILTER_TYPE !== 1'b1 || oSWITCH_CNT !== exp_cnt()) begin
      n_fail++;
      $display("FAIL pend_applied: got flush=%0d sel=%b ft=%b cnt=%0d expected 4 1 1 %0d",
               flush_seen, oSEL_CONV, oFILTER_TYPE, oSWITCH_CNT, exp_cnt());
    end
  endtask

  // Async reset while priming: outputs return to reset values within the same cycle
  task automatic test_reset_mid();
    repeat (8) drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (oBUSY !== 1'b1 || oSEL_CONV !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got busy=%b sel=%b expected 1 1", oBUSY, oSEL_CONV);
    end
    iMODE_REQ = 2'b00;
    @(posedge iCLK);
    #2;
    iDVAL_RAW = 1'b1; iDVAL_CONV = 1'b1; iLVAL = 1'b1;
    iRST = 1'b1;
    #1;
    n_switch = 0;
    n_checks++;
    if ({oFILTER_TYPE, oSEL_CONV, oFLUSH, oVALID, oBUSY} !== 5'b00001 || oSWITCH_CNT !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid: got ft/sel/flush/valid/busy=%b cnt=%0d expected 00001 0",
               {oFILTER_TYPE, oSEL_CONV, oFLUSH, oVALID, oBUSY}, oSWITCH_CNT);
    end
    @(posedge iCLK);
    #1;
    iRST = 1'b0; iFVAL = 1'b0; iLVAL = 1'b0; iDVAL_RAW = 1'b0; iDVAL_CONV = 1'b0;
  endtask

  // 300 switches between the two non-conv filter types; counter saturates
  task automatic test_saturation();
    logic [1:0] req;
    for (int i = 0; i < 300; i++) begin
      req = {1'b0, ~i[0]};
      iMODE_REQ = req;
      repeat (DEB + 8) drive(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (12) drive(1'b0, 1'b0, 1'b0, 1'b0);
      n_switch++;
      n_checks++;
      if (oSWITCH_CNT !== exp_cnt() || oFILTER_TYPE !== req[0] || oSEL_CONV !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_iter%0d: got cnt=%0d ft=%b sel=%b expected %0d %b 0",
                 i, oSWITCH_CNT, oFILTER_TYPE, oSEL_CONV, exp_cnt(), req[0]);
      end
    end
  endtask

  initial begin
    iRST = 1'b1;
    iMODE_REQ = 2'b00;
    iFVAL = 1'b0; iLVAL = 1'b0; iDVAL_RAW = 1'b0; iDVAL_CONV = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    test_reset();
    test_run_raw();
    test_switch_conv();
    test_prime();
    test_glitch();
    test_pending_update();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
